// File: rtl/liang_pkg.sv
// Shared types and constants for the register scoreboard.
package liang_pkg;
  localparam int SB_CNT_W = 2;
  typedef logic [4:0]          reg_idx_t;
  typedef logic [SB_CNT_W-1:0] sb_cnt_t;
endpackage

// File: rtl/sb_counter.sv
// One pending-write counter: saturating up/down with synchronous clear.
module sb_counter
  import liang_pkg::*;
#(
  parameter int CNT_W = SB_CNT_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  input  logic             dec_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             zero_o,
  output logic             max_o,
  output logic             underflow_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign cnt_o  = cnt_q;
  assign zero_o = (cnt_q == '0);
  assign max_o  = &cnt_q;
  // Simultaneous inc and dec cancel, so neither limit is checked then.
  assign underflow_o = dec_i & ~inc_i & zero_o;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                             cnt_d = '0;
    else if (inc_i && !dec_i && !max_o)    cnt_d = cnt_q + 1'b1;
    else if (dec_i && !inc_i && !zero_o)   cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
endmodule

// File: rtl/pipe_scoreboard.sv
// Register scoreboard beside the ID stage: counts outstanding rd writes between
// issue and WB retire, and stalls ID on RAW hazards or counter saturation.
module pipe_scoreboard
  import liang_pkg::*;
#(
  parameter int NUM_REGS      = 32,
  parameter int CNT_W         = SB_CNT_W,
  parameter bit RETIRE_BYPASS = 1'b0,
  parameter int INFL_W        = 4,
  localparam int IDX_W        = $clog2(NUM_REGS)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                flush_i,
  input  logic                rs1_ren_i,
  input  logic [IDX_W-1:0]    rs1_i,
  input  logic                rs2_ren_i,
  input  logic [IDX_W-1:0]    rs2_i,
  input  logic                rd_wen_i,
  input  logic [IDX_W-1:0]    rd_i,
  input  logic                issue_i,
  input  logic                ret_wen_i,
  input  logic [IDX_W-1:0]    ret_rd_i,
  output logic                stall_o,
  output logic [NUM_REGS-1:0] busy_o,
  output logic [INFL_W-1:0]   inflight_o,
  output logic                err_o
);
  logic [NUM_REGS-1:0][CNT_W-1:0] cnt;
  logic [NUM_REGS-1:0]            zero, maxed, uf;
  logic                           haz1, haz2, sat, issue_ok, retire_ok, any_uf;
  logic                           inf_inc, inf_dec, inf_ovf;
  logic [INFL_W-1:0]              inflight_q, inflight_d;
  logic                           err_q, err_d;

  // x0 is hardwired: never busy, never saturated, never underflows.
  assign cnt[0]   = '0;
  assign zero[0]  = 1'b1;
  assign maxed[0] = 1'b0;
  assign uf[0]    = 1'b0;

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_cnt
    sb_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .inc_i       (issue_ok  && (rd_i     == IDX_W'(r))),
      .dec_i       (retire_ok && (ret_rd_i == IDX_W'(r))),
      .clr_i       (flush_i),
      .cnt_o       (cnt[r]),
      .zero_o      (zero[r]),
      .max_o       (maxed[r]),
      .underflow_o (uf[r])
    );
  end

  // A retire of the last pending write can forward through the regfile.
  assign haz1 = rs1_ren_i && (rs1_i != '0) && !zero[rs1_i] &&
                !(RETIRE_BYPASS && ret_wen_i && (ret_rd_i == rs1_i) && (cnt[rs1_i] == CNT_W'(1)));
  assign haz2 = rs2_ren_i && (rs2_i != '0) && !zero[rs2_i] &&
                !(RETIRE_BYPASS && ret_wen_i && (ret_rd_i == rs2_i) && (cnt[rs2_i] == CNT_W'(1)));
  assign sat     = rd_wen_i && (rd_i != '0) && maxed[rd_i];
  assign stall_o = haz1 | haz2 | sat;

  assign issue_ok  = issue_i && rd_wen_i && (rd_i != '0) && !stall_o && !flush_i;
  assign retire_ok = ret_wen_i && (ret_rd_i != '0);
  assign any_uf    = |uf;

  assign inf_inc = issue_ok;
  assign inf_dec = retire_ok && !any_uf;
  assign inf_ovf = inf_inc && !inf_dec && (inflight_q == '1);

  always_comb begin
    inflight_d = inflight_q;
    if (flush_i)                                    inflight_d = '0;
    else if (inf_inc && !inf_dec && !inf_ovf)       inflight_d = inflight_q + 1'b1;
    else if (inf_dec && !inf_inc && inflight_q != '0) inflight_d = inflight_q - 1'b1;
  end

  always_comb begin
    err_d = err_q;
    if (!flush_i && ((issue_i && stall_o) || any_uf || inf_ovf)) err_d = 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      inflight_q <= '0;
      err_q      <= 1'b0;
    end else begin
      inflight_q <= inflight_d;
      err_q      <= err_d;
    end

  assign busy_o     = ~zero;
  assign inflight_o = inflight_q;
  assign err_o      = err_q;
endmodule

// File: tb/tb_pipe_scoreboard.sv
// Directed table-driven bench for pipe_scoreboard, plus hand sequences for
// async reset, issue-under-stall, retire bypass and inflight saturation.
module tb_pipe_scoreboard;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, flush, r1e, r2e, wen, iss, rw;
  logic [4:0]  r1, r2, rd, rrd;
  logic        stall_a, stall_b, err_a, err_b;
  logic [31:0] busy_a, busy_b;
  logic [3:0]  infl_a, infl_b;

  int checks = 0;
  int failures = 0;

  pipe_scoreboard #(.RETIRE_BYPASS(1'b0)) dut_a (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .rs1_ren_i(r1e), .rs1_i(r1), .rs2_ren_i(r2e), .rs2_i(r2),
    .rd_wen_i(wen), .rd_i(rd), .issue_i(iss), .ret_wen_i(rw), .ret_rd_i(rrd),
    .stall_o(stall_a), .busy_o(busy_a), .inflight_o(infl_a), .err_o(err_a));

  pipe_scoreboard #(.RETIRE_BYPASS(1'b1)) dut_b (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .rs1_ren_i(r1e), .rs1_i(r1), .rs2_ren_i(r2e), .rs2_i(r2),
    .rd_wen_i(wen), .rd_i(rd), .issue_i(iss), .ret_wen_i(rw), .ret_rd_i(rrd),
    .stall_o(stall_b), .busy_o(busy_b), .inflight_o(infl_b), .err_o(err_b));

  typedef struct {
    logic fl, r1e; logic [4:0] r1; logic r2e; logic [4:0] r2;
    logic wen; logic [4:0] rd; logic iss, rw; logic [4:0] rrd;
    logic e_stall; logic [31:0] e_busy; logic [3:0] e_infl; logic e_err;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [31:0] b(input int n);
    logic [31:0] one = 32'h1;
    return one << n;
  endfunction

  function automatic vec_t v(input logic fl, r1e_, input logic [4:0] r1_, input logic r2e_,
                             input logic [4:0] r2_, input logic wen_, input logic [4:0] rd_,
                             input logic iss_, rw_, input logic [4:0] rrd_, input logic st,
                             input logic [31:0] bs, input logic [3:0] inf, input logic er);
    vec_t t;
    t.fl = fl; t.r1e = r1e_; t.r1 = r1_; t.r2e = r2e_; t.r2 = r2_;
    t.wen = wen_; t.rd = rd_; t.iss = iss_; t.rw = rw_; t.rrd = rrd_;
    t.e_stall = st; t.e_busy = bs; t.e_infl = inf; t.e_err = er;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic set_in(input vec_t t);
    flush = t.fl; r1e = t.r1e; r1 = t.r1; r2e = t.r2e; r2 = t.r2;
    wen = t.wen; rd = t.rd; iss = t.iss; rw = t.rw; rrd = t.rrd;
  endtask

  task automatic idle();
    flush = 0; r1e = 0; r1 = 0; r2e = 0; r2 = 0; wen = 0; rd = 0; iss = 0; rw = 0; rrd = 0;
  endtask

  // Drive one cycle of inputs; stall is combinational, state settles after the edge.
  task automatic apply(input vec_t t, input string nm);
    set_in(t);
    @(negedge clk);
    chk({nm, ".stall"}, 32'(stall_a), 32'(t.e_stall));
    @(posedge clk); #1;
    chk({nm, ".busy"}, busy_a, t.e_busy);
    chk({nm, ".infl"}, 32'(infl_a), 32'(t.e_infl));
    chk({nm, ".err"}, 32'(err_a), 32'(t.e_err));
    idle();
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 0;
    @(posedge clk); #1;
  endtask

  task automatic issue_rd(input logic [4:0] r);
    wen = 1; rd = r; iss = 1;
    @(posedge clk); #1;
    idle();
  endtask

  initial begin
    idle();
    rst = 1;
    #1;
    chk("rst.busy", busy_a, 32'h0);
    chk("rst.infl", 32'(infl_a), 32'h0);
    chk("rst.err", 32'(err_a), 32'h0);
    do_reset();

    //        fl r1e r1 r2e r2 wen rd iss rw rrd   stall busy        infl err
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0,          0, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 1, 5, 1, 0, 0,  0, b(5),       1, 0));
    tbl.push_back(v(0, 1, 5, 0, 0, 0, 0, 0, 0, 0,  1, b(5),       1, 0));
    tbl.push_back(v(0, 1, 5, 0, 0, 0, 0, 0, 1, 5,  1, 0,          0, 0));
    tbl.push_back(v(0, 1, 5, 0, 0, 0, 0, 0, 0, 0,  0, 0,          0, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 1, 7, 1, 0, 0,  0, b(7),       1, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 1, 7, 1, 0, 0,  0, b(7),       2, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 1, 7, 1, 0, 0,  0, b(7),       3, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 1, 7, 0, 0, 0,  1, b(7),       3, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 1, 7, 0, 1, 7,  1, b(7),       2, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 1, 7, 1, 0, 0,  0, b(7),       3, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 1, 7,  0, b(7),       2, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 1, 7,  0, b(7),       1, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 1, 7,  0, 0,          0, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 1, 9, 1, 0, 0,  0, b(9),       1, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 1, 9, 1, 1, 9,  0, b(9),       1, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 1, 9,  0, 0,          0, 0));
    tbl.push_back(v(0, 0, 0, 1, 0, 1, 0, 1, 0, 0,  0, 0,          0, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 1, 12, 1, 0, 0, 0, b(12),      1, 0));
    tbl.push_back(v(0, 0, 0, 1, 12, 0, 0, 0, 0, 0, 1, b(12),      1, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 1, 12, 0, 0,          0, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 1, 4, 1, 0, 0,  0, b(4),       1, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 1, 4, 1, 0, 0,  0, b(4),       2, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 1, 6, 1, 0, 0,  0, b(4)|b(6),  3, 0));
    tbl.push_back(v(1, 0, 0, 0, 0, 1, 8, 1, 1, 4,  0, 0,          0, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 1, 0,  0, 0,          0, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 1, 3,  0, 0,          0, 1));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0,          0, 1));

    foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

    // Async reset mid-cycle with cnt[5]=2 and err already set.
    apply(v(0, 0, 0, 0, 0, 1, 5, 1, 0, 0, 0, b(5), 1, 1), "pre_rst0");
    apply(v(0, 0, 0, 0, 0, 1, 5, 1, 0, 0, 0, b(5), 2, 1), "pre_rst1");
    #2 rst = 1;
    #1;
    chk("arst.busy", busy_a, 32'h0);
    chk("arst.infl", 32'(infl_a), 32'h0);
    chk("arst.err", 32'(err_a), 32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 0;
    @(posedge clk); #1;

    // Issue while stalled: dropped and flagged.
    apply(v(0, 0, 0, 0, 0, 1, 5, 1, 0, 0, 0, b(5), 1, 0), "stl0");
    apply(v(0, 1, 5, 0, 0, 1, 6, 1, 0, 0, 1, b(5), 1, 1), "stl_issue");

    // Retire bypass: only the last pending write forwards.
    do_reset();
    issue_rd(5);
    r1e = 1; r1 = 5; rw = 1; rrd = 5;
    @(negedge clk);
    chk("byp0.stall_a", 32'(stall_a), 32'h1);
    chk("byp0.stall_b", 32'(stall_b), 32'h0);
    @(posedge clk); #1;
    idle();
    issue_rd(5);
    issue_rd(5);
    r1e = 1; r1 = 5; rw = 1; rrd = 5;
    @(negedge clk);
    chk("byp_cnt2.stall_b", 32'(stall_b), 32'h1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("byp_cnt1.stall_b", 32'(stall_b), 32'h0);
    chk("byp_cnt1.stall_a", 32'(stall_a), 32'h1);
    @(posedge clk); #1;
    idle();
    chk("byp.busy_b", busy_b, 32'h0);

    // Inflight saturates at 15 and flags the overflowing increment.
    do_reset();
    for (int r = 1; r <= 5; r++)
      for (int k = 0; k < 3; k++) issue_rd(5'(r));
    chk("infl_full", 32'(infl_a), 32'd15);
    chk("infl_full.err", 32'(err_a), 32'h0);
    issue_rd(6);
    chk("infl_sat", 32'(infl_a), 32'd15);
    chk("infl_sat.err", 32'(err_a), 32'h1);
    chk("infl_sat.busy6", 32'(busy_a[6]), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
